// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter stage with one-entry pending redirect buffer
// Selects sequential, branch, jump or register-jump targets and holds redirects across stalls.
module pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_imm,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        redirect_pending,
    output logic        addr_err
);

    logic [31:0] base;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] jr_target;
    logic [31:0] sel_target;
    logic [31:0] pending_target;
    logic        redirect_req;
    logic        jr_misaligned;

    assign base          = redirect_pc + 32'd4;
    assign branch_target = base + {{14{branch_imm[15]}}, branch_imm, 2'b00};
    assign jump_target   = {base[31:28], jump_index, 2'b00};
    assign jr_target     = {jr_addr[31:2], 2'b00};
    assign redirect_req  = jr | jump | branch_taken;
    assign jr_misaligned = jr & (jr_addr[1:0] != 2'b00);
    assign pc_plus4      = pc + 32'd4;

    // Fixed priority: register jump beats direct jump beats branch.
    always_comb begin
        sel_target = branch_target;
        if (jr) begin
            sel_target = jr_target;
        end else if (jump) begin
            sel_target = jump_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc               <= RESET_PC;
            redirect_pending <= 1'b0;
            pending_target   <= 32'h0000_0000;
            addr_err         <= 1'b0;
        end else begin
            if (jr_misaligned) begin
                addr_err <= 1'b1;
            end
            if (!stall) begin
                redirect_pending <= 1'b0;
                if (redirect_req) begin
                    pc <= sel_target;
                end else if (redirect_pending) begin
                    pc <= pending_target;
                end else begin
                    pc <= pc_plus4;
                end
            end else if (redirect_req) begin
                // Latest redirect wins; an older buffered one is discarded.
                redirect_pending <= 1'b1;
                pending_target   <= sel_target;
            end
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - self-checking bench for pc_unit with directed and random stimulus
// Reference model tracks architectural PC, pending redirect and error flag.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_imm = 16'h0;
    logic        jump = 1'b0;
    logic [25:0] jump_index = 26'h0;
    logic        jr = 1'b0;
    logic [31:0] jr_addr = 32'h0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        redirect_pending;
    logic        addr_err;

    int tests = 0;
    int fails = 0;

    logic [31:0] m_pc = 32'h0;
    logic        m_pend = 1'b0;
    logic [31:0] m_ptgt = 32'h0;
    logic        m_err = 1'b0;

    pc_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .branch_taken(branch_taken),
        .branch_imm(branch_imm),
        .jump(jump),
        .jump_index(jump_index),
        .jr(jr),
        .jr_addr(jr_addr),
        .redirect_pc(redirect_pc),
        .pc(pc),
        .pc_plus4(pc_plus4),
        .redirect_pending(redirect_pending),
        .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc   = 32'h0;
        m_pend = 1'b0;
        m_ptgt = 32'h0;
        m_err  = 1'b0;
    endtask

    task automatic model_edge();
        logic [31:0] b;
        logic [31:0] tgt;
        logic        req;
        b   = redirect_pc + 32'd4;
        req = jr | jump | branch_taken;
        if (jr)
            tgt = jr_addr & 32'hFFFF_FFFC;
        else if (jump)
            tgt = (b & 32'hF000_0000) | ({6'd0, jump_index} << 2);
        else
            tgt = b + 32'(int'($signed(branch_imm)) * 4);
        if (jr && (jr_addr % 4 != 0))
            m_err = 1'b1;
        if (!stall) begin
            if (req)
                m_pc = tgt;
            else if (m_pend)
                m_pc = m_ptgt;
            else
                m_pc = m_pc + 32'd4;
            m_pend = 1'b0;
        end else if (req) begin
            m_pend = 1'b1;
            m_ptgt = tgt;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        branch_taken = 1'b0;
        jump = 1'b0;
        jr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        #3;
        tests++;
        if (pc !== 32'h0) begin
            fails++;
            $display("FAIL reset_pc actual=%h expected=%h", pc, 32'h0);
        end
        tests++;
        if (redirect_pending !== 1'b0 || addr_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags actual=%b%b expected=00", redirect_pending, addr_err);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 4; i++) begin
            tick();
            tests++;
            if (pc !== 32'(i * 4) || pc_plus4 !== 32'(i * 4 + 4) || redirect_pending !== 1'b0) begin
                fails++;
                $display("FAIL seq_%0d actual pc=%h p4=%h pend=%b expected pc=%h p4=%h pend=0",
                         i, pc, pc_plus4, redirect_pending, 32'(i * 4), 32'(i * 4 + 4));
            end
        end
    endtask

    task automatic test_backward_branch();
        redirect_pc  = 32'h20;
        branch_imm   = 16'hFFFC;
        branch_taken = 1'b1;
        tick();
        clear_inputs();
        tests++;
        if (pc !== 32'h14) begin
            fails++;
            $display("FAIL branch_target actual=%h expected=%h", pc, 32'h14);
        end
        tick();
        tests++;
        if (pc !== 32'h18) begin
            fails++;
            $display("FAIL branch_next actual=%h expected=%h", pc, 32'h18);
        end
    endtask

    task automatic test_jump_stall();
        stall       = 1'b1;
        jump        = 1'b1;
        redirect_pc = 32'h1000_0040;
        jump_index  = 26'h10;
        tick();
        clear_inputs();
        tests++;
        if (pc !== 32'h18 || redirect_pending !== 1'b1) begin
            fails++;
            $display("FAIL jump_stall_hold actual pc=%h pend=%b expected pc=%h pend=1",
                     pc, redirect_pending, 32'h18);
        end
        tick();
        stall = 1'b0;
        tick();
        tests++;
        if (pc !== 32'h1000_0040 || redirect_pending !== 1'b0) begin
            fails++;
            $display("FAIL jump_release actual pc=%h pend=%b expected pc=%h pend=0",
                     pc, redirect_pending, 32'h1000_0040);
        end
    endtask

    task automatic test_priority();
        jr           = 1'b1;
        jr_addr      = 32'h200;
        branch_taken = 1'b1;
        redirect_pc  = 32'h40;
        branch_imm   = 16'h0010;
        tick();
        clear_inputs();
        tests++;
        if (pc !== 32'h200) begin
            fails++;
            $display("FAIL priority_jr actual=%h expected=%h", pc, 32'h200);
        end
        stall       = 1'b1;
        jump        = 1'b1;
        redirect_pc = 32'h0;
        jump_index  = 26'h80;
        tick();
        clear_inputs();
        jr      = 1'b1;
        jr_addr = 32'h300;
        tick();
        clear_inputs();
        stall = 1'b0;
        tick();
        tests++;
        if (pc !== 32'h300 || redirect_pending !== 1'b0) begin
            fails++;
            $display("FAIL override actual pc=%h pend=%b expected pc=%h pend=0",
                     pc, redirect_pending, 32'h300);
        end
    endtask

    task automatic test_misaligned_jr();
        jr      = 1'b1;
        jr_addr = 32'h0000_0106;
        tick();
        clear_inputs();
        tests++;
        if (pc !== 32'h104 || addr_err !== 1'b1) begin
            fails++;
            $display("FAIL misaligned_jr actual pc=%h err=%b expected pc=%h err=1",
                     pc, addr_err, 32'h104);
        end
        for (int i = 0; i < 10; i++) tick();
        tests++;
        if (addr_err !== 1'b1 || pc !== 32'h12C) begin
            fails++;
            $display("FAIL addr_err_sticky actual err=%b pc=%h expected err=1 pc=%h",
                     addr_err, pc, 32'h12C);
        end
    endtask

    task automatic test_async_reset();
        stall       = 1'b1;
        jump        = 1'b1;
        redirect_pc = 32'h0;
        jump_index  = 26'h55;
        tick();
        clear_inputs();
        tests++;
        if (redirect_pending !== 1'b1) begin
            fails++;
            $display("FAIL async_pre_pending actual=%b expected=1", redirect_pending);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        tests++;
        if (pc !== 32'h0 || redirect_pending !== 1'b0 || addr_err !== 1'b0) begin
            fails++;
            $display("FAIL async_reset actual pc=%h pend=%b err=%b expected pc=0 pend=0 err=0",
                     pc, redirect_pending, addr_err);
        end
        @(negedge clk);
        rst   = 1'b0;
        stall = 1'b0;
        tick();
        tests++;
        if (pc !== 32'h4) begin
            fails++;
            $display("FAIL after_reset actual=%h expected=%h", pc, 32'h4);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            stall        = ($urandom_range(0, 9) < 3);
            branch_taken = ($urandom_range(0, 4) == 0);
            jump         = ($urandom_range(0, 5) == 0);
            jr           = ($urandom_range(0, 6) == 0);
            branch_imm   = 16'($urandom);
            jump_index   = 26'($urandom);
            jr_addr      = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            redirect_pc  = $urandom & 32'hFFFF_FFFC;
            if (i == 200) begin
                jr = 1'b0; jump = 1'b0; branch_taken = 1'b0; stall = 1'b0;
            end
            tick();
            tests++;
            if (pc !== m_pc || pc_plus4 !== m_pc + 32'd4 ||
                redirect_pending !== m_pend || addr_err !== m_err) begin
                fails++;
                $display("FAIL random_%0d actual pc=%h p4=%h pend=%b err=%b expected pc=%h p4=%h pend=%b err=%b",
                         i, pc, pc_plus4, redirect_pending, addr_err,
                         m_pc, m_pc + 32'd4, m_pend, m_err);
            end
        end
        clear_inputs();
        stall = 1'b0;
    endtask

    task automatic test_wrap();
        jr      = 1'b1;
        jr_addr = 32'hFFFF_FFFC;
        tick();
        clear_inputs();
        tick();
        tests++;
        if (pc !== 32'h0 || pc !== m_pc) begin
            fails++;
            $display("FAIL wrap actual=%h expected=%h", pc, 32'h0);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backward_branch();
        test_jump_stall();
        test_priority();
        test_misaligned_jr();
        test_async_reset();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
